// File: rtl/reg_bank_pkg.sv
// Shared constants and address type for the multi-port register bank.
package reg_bank_pkg;
  localparam int unsigned DEFAULT_N     = 32;
  localparam int unsigned DEFAULT_DEPTH = 16;
  localparam int unsigned DEFAULT_AW    = $clog2(DEFAULT_DEPTH);

  typedef logic [DEFAULT_AW-1:0] reg_addr_t;
endpackage

// File: rtl/reg_scoreboard.sv
// Pending-writeback scoreboard: one busy bit per register plus a sticky
// error flag for reserving a register that is already pending.
module reg_scoreboard
  import reg_bank_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          write,
  input  logic [AW-1:0] dest,
  input  logic          rsv,
  input  logic [AW-1:0] rsv_dest,
  input  logic [AW-1:0] src1,
  input  logic [AW-1:0] src2,
  input  logic [AW-1:0] src3,
  output logic          busy1,
  output logic          busy2,
  output logic          busy3,
  output logic          rsv_err
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             err_set;

  // Reservation is applied after the write clear so a same-cycle
  // write+reserve of one register leaves it busy.
  always_comb begin
    busy_d = busy_q;
    if (write) busy_d[dest] = 1'b0;
    if (rsv) busy_d[rsv_dest] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    err_set = rsv && (rsv_dest != '0) && busy_q[rsv_dest]
              && !(write && (dest == rsv_dest));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      rsv_err <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (err_set) rsv_err <= 1'b1;
    end
  end

  assign busy1 = busy_q[src1];
  assign busy2 = busy_q[src2];
  assign busy3 = busy_q[src3];

endmodule

// File: rtl/reg_bank_mp.sv
// Register bank with two enabled read ports, one free-running read port,
// one write port and a pending-writeback scoreboard.
// Optional write-to-read bypass: define REG_BANK_BYPASS_EN.
module reg_bank_mp
  import reg_bank_pkg::*;
#(
  parameter int unsigned N     = DEFAULT_N,
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          read1,
  input  logic          read2,
  input  logic [AW-1:0] src1,
  input  logic [AW-1:0] src2,
  input  logic [AW-1:0] src3,
  output logic [N-1:0]  r_data1,
  output logic [N-1:0]  r_data2,
  output logic [N-1:0]  r_data3,
  input  logic          write,
  input  logic [AW-1:0] dest,
  input  logic [N-1:0]  w_data,
  input  logic          rsv,
  input  logic [AW-1:0] rsv_dest,
  output logic          busy1,
  output logic          busy2,
  output logic          busy3,
  output logic          rsv_err
);

  logic [N-1:0] regs [DEPTH];
  logic [N-1:0] rd1, rd2, rd3;
  logic         wr_en;

  assign wr_en = write && (dest != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[dest] <= w_data;
    end
  end

  // Register 0 is never written, so it always reads back its reset value.
  always_comb begin
    rd1 = regs[src1];
    rd2 = regs[src2];
    rd3 = regs[src3];
`ifdef REG_BANK_BYPASS_EN
    if (wr_en && (dest == src1)) rd1 = w_data;
    if (wr_en && (dest == src2)) rd2 = w_data;
    if (wr_en && (dest == src3)) rd3 = w_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data1 <= '0;
      r_data2 <= '0;
      r_data3 <= '0;
    end else begin
      if (read1) r_data1 <= rd1;
      if (read2) r_data2 <= rd2;
      r_data3 <= rd3;
    end
  end

  reg_scoreboard #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .write    (write),
    .dest     (dest),
    .rsv      (rsv),
    .rsv_dest (rsv_dest),
    .src1     (src1),
    .src2     (src2),
    .src3     (src3),
    .busy1    (busy1),
    .busy2    (busy2),
    .busy3    (busy3),
    .rsv_err  (rsv_err)
  );

endmodule

// File: doc/reg_bank_mp.md
REG_BANK_MP -- requirements
Module: reg_bank_mp

Interface
REQ-001 Parameter N, default 32, data width in bits.
REQ-002 Parameter DEPTH, default 16, register count; power of two, at least 2.
REQ-003 Parameter AW, default $clog2(DEPTH), register address width.
REQ-004 The module SHALL have one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  the only clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 read1, read2  input  1 each  read enables for ports 1 and 2.
REQ-008 src1, src2, src3  input  AW each  read addresses.
REQ-009 r_data1, r_data2, r_data3  output  N each  registered read data.
REQ-010 write  input  1  write enable.
REQ-011 dest  input  AW  write address.
REQ-012 w_data  input  N  write data.
REQ-013 rsv  input  1  reserve request; marks rsv_dest as pending writeback.
REQ-014 rsv_dest  input  AW  register to reserve.
REQ-015 busy1, busy2, busy3  output  1 each  combinational pending flag for src1, src2 and src3.
REQ-016 rsv_err  output  1  sticky flag for reservation of an already-busy register.

Function
REQ-017 Register 0 SHALL read as 0, ignore writes and reservations, and never be busy.
REQ-018 When write=1 and dest!=0, w_data SHALL be stored at dest on the rising edge.
REQ-019 r_data1 SHALL load the contents at src1 one cycle after a cycle with read1=1, and SHALL hold its value otherwise; r_data2 follows the same rule with read2.
REQ-020 r_data3 SHALL load the contents at src3 on every cycle.
REQ-021 A write SHALL clear the busy bit of dest; when rsv=1 with rsv_dest==dest in the same cycle, the register SHALL remain busy.
REQ-022 When rsv=1 and rsv_dest!=0, the busy bit of rsv_dest SHALL be set on the rising edge.
REQ-023 When rsv=1 targets a register that is busy and not being written in the same cycle, rsv_err SHALL be set and SHALL stay set until reset.
REQ-024 busyK SHALL reflect the current scoreboard bit of srcK with no latency; it does not include same-cycle updates.
REQ-025 Two reads of the same address in one cycle SHALL return identical data.

Reset
REQ-026 While rst=1 at a rising edge, all registers, all busy bits, r_data1-3 and rsv_err SHALL become 0, and write and rsv SHALL be ignored.
REQ-027 When reset is asserted mid-operation, it SHALL discard any in-flight reservation; the first write after reset SHALL behave as a normal write.

Configuration
REQ-028 With macro REG_BANK_BYPASS_EN defined: when write=1, dest!=0, dest==srcK and port K is loading, r_dataK SHALL capture w_data in that cycle.
REQ-029 Without REG_BANK_BYPASS_EN, r_dataK SHALL capture the pre-write contents, and the new value SHALL be visible one cycle later.

Structure
REQ-030 Package reg_bank_pkg SHALL hold the default N and DEPTH constants and a reg_addr_t typedef.
REQ-031 The busy bits and rsv_err logic SHALL live in sub-module reg_scoreboard, which is instantiated once.

Verification
REQ-032 Reset, then write 0xDEADBEEF to register 5, then read1=1 with src1=5 one cycle later -> r_data1=0xDEADBEEF on the following cycle.
REQ-033 Write 0x1234 to register 0, then read src3=0 -> r_data3=0 and busy3=0.
REQ-034 Same cycle: write=1, dest=7, w_data=0xAA, read2=1, src2=7, register 7 previously 0x55 -> r_data2=0xAA with REG_BANK_BYPASS_EN, 0x55 without it.
REQ-035 rsv on register 3 -> busy1=1 for src1=3 on the next cycle; write to 3 -> busy1=0 next cycle; write to 3 together with rsv on 3 -> busy1 stays 1.
REQ-036 rsv on register 4 twice without an intervening write -> rsv_err=1; it holds through idle cycles and clears only on rst=1.
REQ-037 Hold read1=0 while register 9 changes -> r_data1 is unchanged; rst=1 mid-sequence -> all outputs are 0 on the next cycle.
